// File: rtl/pred_update_arbiter.sv
// pred_update_arbiter: queues branch-resolution updates and drains them
// onto the shared BTB/gshare write port, yielding to fetch lookups.
// Ports: clk, rst_n (sync, active-low); upd_valid_i/upd_i/upd_ready_o
// update handshake; fetch_req_i/fetch_stall_o fetch port arbitration;
// btb_wr_* and gsh_wr_* registered write pulses; count_o FIFO occupancy.
// Optional: define PRED_UPD_STATS_EN to add forced_cnt_o and
// full_cycles_o saturating statistics counters.
module pred_update_arbiter #(
  parameter int QUEUE_DEPTH      = 4,
  parameter int PC_BITS          = 32,
  parameter int BTB_SIZE         = 256,
  parameter int GSH_SIZE         = 256,
  parameter int GSH_HISTORY_BITS = 2,
  parameter int STARVE_LIMIT     = 8,
  localparam int BI = $clog2(BTB_SIZE),
  localparam int GI = $clog2(GSH_SIZE),
  localparam int CW = $clog2(QUEUE_DEPTH) + 1,
  localparam int UW = 8 + 2 * PC_BITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               upd_valid_i,
  input  logic [UW-1:0]      upd_i,
  output logic               upd_ready_o,
  input  logic               fetch_req_i,
  output logic               fetch_stall_o,
  output logic               btb_wr_en_o,
  output logic [BI-1:0]      btb_wr_idx_o,
  output logic [PC_BITS-1:0] btb_wr_orig_pc_o,
  output logic [PC_BITS-1:0] btb_wr_target_o,
  output logic               gsh_wr_en_o,
  output logic [GI-1:0]      gsh_wr_idx_o,
  output logic               gsh_taken_o,
  output logic [CW-1:0]      count_o
`ifdef PRED_UPD_STATS_EN
  ,
  output logic [15:0]        forced_cnt_o,
  output logic [15:0]        full_cycles_o
`endif
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT) + 1;
  localparam int H  = GSH_HISTORY_BITS;
  localparam int EW = 1 + 2 * PC_BITS;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_READY,
    S_FORCE
  } state_t;

  state_t state, state_nxt;

  logic [EW-1:0]      mem [QUEUE_DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_nxt;
  logic [SW-1:0]      starve_cnt;
  logic [H-1:0]       ghr;
  logic [H:0]         ghr_sh;
  logic [GI-1:0]      ghr_ext;

  logic               in_vj;
  logic               in_tk;
  logic [PC_BITS-1:0] in_pc;
  logic [PC_BITS-1:0] in_tgt;
  logic               unused_upd;

  logic [EW-1:0]      head;
  logic               head_tk;
  logic [PC_BITS-1:0] head_pc;
  logic [PC_BITS-1:0] head_tgt;

  logic               push;
  logic               pop;

  // Packet layout: {vj, taken, is_comp, rat_id[1:0], orig_pc,
  // jump_address, ticket[2:0]}.
  assign in_vj  = upd_i[UW-1];
  assign in_tk  = upd_i[UW-2];
  assign in_pc  = upd_i[PC_BITS+3 +: PC_BITS];
  assign in_tgt = upd_i[3 +: PC_BITS];
  assign unused_upd = ^{upd_i[UW-3:UW-5], upd_i[2:0]};

  assign head     = mem[rd_ptr];
  assign head_tk  = head[EW-1];
  assign head_pc  = head[PC_BITS +: PC_BITS];
  assign head_tgt = head[PC_BITS-1:0];

  assign upd_ready_o = (count < CW'(QUEUE_DEPTH));
  assign count_o     = count;

  // Non-jump handshakes are acknowledged but never queued.
  assign push = upd_valid_i & upd_ready_o & in_vj;
  assign pop  = (count != '0) &
                (((state == S_READY) & ~fetch_req_i) |
                 (state == S_FORCE));

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    ghr_ext        = '0;
    ghr_ext[H-1:0] = ghr;
    ghr_sh         = {ghr, head_tk};
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_EMPTY;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == S_EMPTY): begin
        if (push) state_nxt = S_READY;
      end
      (state == S_READY): begin
        if (!fetch_req_i) begin
          if (count_nxt == '0) state_nxt = S_EMPTY;
        end else if (starve_cnt == SW'(STARVE_LIMIT - 1)) begin
          state_nxt = S_FORCE;
        end
      end
      (state == S_FORCE): begin
        state_nxt = (count_nxt == '0) ? S_EMPTY : S_READY;
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  // FSM: outputs
  always_comb begin
    fetch_stall_o = 1'b0;
    if (state == S_FORCE) fetch_stall_o = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_tk, in_pc, in_tgt};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      ghr        <= '0;
    end else begin
      count <= count_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + PW'(1);
        starve_cnt <= '0;
        ghr        <= ghr_sh[H-1:0];
      end else if ((state == S_READY) && fetch_req_i) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

  // Index uses the history before this entry shifts in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btb_wr_en_o      <= 1'b0;
      btb_wr_idx_o     <= '0;
      btb_wr_orig_pc_o <= '0;
      btb_wr_target_o  <= '0;
      gsh_wr_en_o      <= 1'b0;
      gsh_wr_idx_o     <= '0;
      gsh_taken_o      <= 1'b0;
    end else begin
      btb_wr_en_o <= pop & head_tk;
      gsh_wr_en_o <= pop;
      if (pop) begin
        btb_wr_idx_o     <= head_pc[2 +: BI];
        btb_wr_orig_pc_o <= head_pc;
        btb_wr_target_o  <= head_tgt;
        gsh_wr_idx_o     <= head_pc[2 +: GI] ^ ghr_ext;
        gsh_taken_o      <= head_tk;
      end
    end
  end

`ifdef PRED_UPD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      forced_cnt_o  <= '0;
      full_cycles_o <= '0;
    end else begin
      if ((state == S_FORCE) && (forced_cnt_o != 16'hFFFF))
        forced_cnt_o <= forced_cnt_o + 16'd1;
      if (!upd_ready_o && (full_cycles_o != 16'hFFFF))
        full_cycles_o <= full_cycles_o + 16'd1;
    end
  end
`endif

endmodule

// File: doc/pred_update_arbiter.md
Name: pred_update_arbiter

Overview:
- Buffers branch-resolution updates (predictor_update packets) coming back from execute.
- Schedules them onto the shared BTB and gshare write port, which is single-ported against fetch lookups.
- Fetch lookups have priority. A starvation counter forces a drain, stalling fetch for one cycle, after STARVE_LIMIT deferred cycles.
- Owns the committed global-history register used to form gshare indices.

Parameters:
- QUEUE_DEPTH, 4, update FIFO entries (power of 2, >=2)
- PC_BITS, 32, PC width
- BTB_SIZE, 256, BTB entries; index width BI = log2(BTB_SIZE)
- GSH_SIZE, 256, gshare counter entries; index width GI = log2(GSH_SIZE)
- GSH_HISTORY_BITS, 2, committed history length (<= GI)
- STARVE_LIMIT, 8, consecutive deferred cycles before a forced drain

Ports:
- clk, input, 1, clock
- rst_n, input, 1, synchronous active-low reset
- upd_valid_i, input, 1, update offered
- upd_i, input, 72, predictor_update {valid_jump, jump_taken, is_comp, rat_id[1:0], orig_pc[31:0], jump_address[31:0], ticket[2:0]}
- upd_ready_o, output, 1, FIFO not full
- fetch_req_i, input, 1, fetch uses predictor port this cycle
- fetch_stall_o, output, 1, fetch must hold its lookup (forced drain)
- btb_wr_en_o, output, 1, BTB write strobe
- btb_wr_idx_o, output, BI, BTB index
- btb_wr_orig_pc_o, output, PC_BITS, tag PC
- btb_wr_target_o, output, PC_BITS, target PC
- gsh_wr_en_o, output, 1, gshare counter update strobe
- gsh_wr_idx_o, output, GI, gshare index
- gsh_taken_o, output, 1, counter direction (1 = increment)
- count_o, output, log2(QUEUE_DEPTH)+1, FIFO occupancy

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, synchronous and active-low.
- Reset values:
  - All write strobes, fetch_stall_o and count_o are 0.
  - upd_ready_o is 1.
  - GHR, starvation counter, and FIFO pointers are 0.
  - State is EMPTY.
  - Reset mid-drain discards all queued entries and any pending write.
- Enqueue:
  - Occurs on upd_valid_i & upd_ready_o & upd_i.valid_jump.
  - Handshakes with valid_jump=0 are accepted and dropped; no FIFO entry, no count change.
  - upd_ready_o = (count < QUEUE_DEPTH). It depends only on registered state, not on the same-cycle pop.
- FIFO: circular, with the pointer wrapping at QUEUE_DEPTH. Simultaneous push and pop leaves count unchanged.
- An entry is visible at head the cycle after push.
- FSM:
  - EMPTY: count==0. On count>0 go to READY.
  - READY: head valid. If !fetch_req_i, pop, clear starve_cnt and stay in READY, or go to EMPTY if the FIFO becomes empty. If fetch_req_i, starve_cnt++; when starve_cnt reaches STARVE_LIMIT-1, go to FORCE.
  - FORCE: pop unconditionally. fetch_stall_o=1 combinationally this cycle. Clear starve_cnt, then go to READY or EMPTY.
  - fetch_stall_o is 1 only in FORCE.
- Write outputs are registered and asserted exactly one cycle after the pop cycle. Each is a one-cycle pulse.
  - Minimum latency is push at t, pop at t+1, write at t+2.
- Write content:
  - gsh_wr_en_o=1 for every popped entry. gsh_taken_o=jump_taken.
  - gsh_wr_idx_o = orig_pc[2+:GI] XOR zero-extended GHR, using the GHR value before this entry's update.
  - btb_wr_en_o=1 only if jump_taken. btb_wr_idx_o=orig_pc[2+:BI], btb_wr_orig_pc_o=orig_pc, btb_wr_target_o=jump_address.
- GHR: on each pop, GHR <= {GHR[H-2:0], jump_taken}, shifting in at the LSB.
- Ordering: strict FIFO; updates are never reordered or merged.

Optional Feature:
- Macro PRED_UPD_STATS_EN.
- When defined, adds output forced_cnt_o (16 bits): a saturating count of FORCE drains, reset to 0, holding at 0xFFFF.
- Also adds output full_cycles_o (16 bits): a saturating count of cycles with upd_ready_o=0.
- When undefined, these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Single update, fetch idle:
  - Stimulus: push {valid_jump=1, taken=1, orig_pc=0x0000_0104, target=0x0000_0200} at cycle 10, fetch_req_i=0.
  - Response: at cycle 12, btb_wr_en_o=1, idx=0x41, target=0x200; gsh_wr_idx_o=0x41 (GHR=0), gsh_taken_o=1; GHR becomes 01.
- Starvation:
  - Stimulus: one entry queued, fetch_req_i held 1.
  - Response: FORCE after 8 deferred cycles; fetch_stall_o=1 for exactly one cycle; write pulse on the next cycle; starve_cnt cleared.
- Full FIFO:
  - Stimulus: push 4 taken updates with fetch_req_i=1.
  - Response: count_o=4, upd_ready_o=0, 5th offer not accepted. Releasing fetch_req_i gives 4 writes on consecutive cycles in push order.
- Not-taken and dropped updates:
  - Stimulus: taken=0 entry with orig_pc=0x0000_0008, then a valid_jump=0 push.
  - Response: gsh_wr_en_o=1, btb_wr_en_o=0, gsh_taken_o=0, idx=0x02. The valid_jump=0 push leaves count_o unchanged.
- Reset mid-drain:
  - Stimulus: 3 entries queued, assert rst_n=0 for one cycle during a pop.
  - Response: next cycle count_o=0, no write pulse, upd_ready_o=1, GHR=0.
- Wrap and simultaneous push/pop:
  - Stimulus: 10 back-to-back pushes with fetch idle.
  - Response: count_o never exceeds 1, pointers wrap, outputs in order with the GHR sequence correct.
